// File: rtl/skolem_chk_pkg.sv
// Shared types, default parameters and helpers for the Skolem exhaustive checker.
package skolem_chk_pkg;

    localparam int unsigned NUM_X_DEF      = 4;
    localparam int unsigned NUM_Y_DEF      = 2;
    localparam int unsigned SETTLE_CYC_DEF = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } chk_state_e;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] max_v;
        max_v   = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        sat_inc = (cnt >= max_v) ? max_v : (cnt + 32'd1);
    endfunction

endpackage

// File: rtl/skolem_exhaustive_checker_if.sv
// Link between the checker and the Skolem netlist / spec evaluator pair.
interface skolem_exhaustive_checker_if #(
    parameter int unsigned NUM_X = 4,
    parameter int unsigned NUM_Y = 2
);
    logic [NUM_X-1:0] x_out;
    logic [NUM_Y-1:0] y_in;
    logic             spec_ok;

    modport master (output x_out, input y_in, input spec_ok);
    modport slave  (input x_out, output y_in, output spec_ok);
endinterface

// File: rtl/skolem_vec_gen.sv
// Assignment index counter and the registered x vector driven into the netlist.
module skolem_vec_gen #(
    parameter int unsigned NUM_X = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    output logic [NUM_X-1:0] x,
    output logic             last_c
);
    // One spare bit so the counter can never alias back to zero.
    localparam int unsigned IDX_W = NUM_X + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'({NUM_X{1'b1}});

    logic [IDX_W-1:0] idx;

    // Index: cleared on a new sweep, stepped after each sample, stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc && (idx != IDX_LAST)) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // x only moves when loaded, keeping the netlist inputs stable otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
        end else if (load) begin
            x <= idx[NUM_X-1:0];
        end
    end

    assign last_c = (idx == IDX_LAST);

endmodule

// File: rtl/skolem_exhaustive_checker.sv
// Sweeps all universal assignments through a Skolem netlist and tallies spec failures.
module skolem_exhaustive_checker
    import skolem_chk_pkg::*;
#(
    parameter int unsigned NUM_X      = NUM_X_DEF,
    parameter int unsigned NUM_Y      = NUM_Y_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned CNT_W      = NUM_X + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    skolem_exhaustive_checker_if.master  bus,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_W-1:0]             fail_count,
    output logic                         cex_valid,
    output logic [NUM_X-1:0]             cex_x,
    output logic [NUM_Y-1:0]             cex_y
);
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic [SET_W-1:0] settle_cnt;

    logic gen_clr;
    logic gen_inc;
    logic gen_load;
    logic last_c;
    logic res_clr;
    logic sample_en;
    logic abort_en;
    logic set_clr;
    logic set_inc;
    logic [NUM_X-1:0] x_q;

    skolem_vec_gen #(.NUM_X(NUM_X)) u_vec_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (gen_clr),
        .inc    (gen_inc),
        .load   (gen_load),
        .x      (x_q),
        .last_c (last_c)
    );

    assign bus.x_out = x_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes; abort overrides everything, including start.
    always_comb begin
        state_nxt = state;
        gen_clr   = 1'b0;
        gen_inc   = 1'b0;
        gen_load  = 1'b0;
        res_clr   = 1'b0;
        sample_en = 1'b0;
        abort_en  = 1'b0;
        set_clr   = 1'b0;
        set_inc   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            abort_en  = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        res_clr   = 1'b1;
                        gen_clr   = 1'b1;
                        state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    gen_load  = 1'b1;
                    set_clr   = 1'b1;
                    state_nxt = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;
                end
                SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state_nxt = SAMPLE;
                    end else begin
                        set_inc = 1'b1;
                    end
                end
                SAMPLE: begin
                    sample_en = 1'b1;
                    if (last_c) begin
                        state_nxt = DONE;
                    end else begin
                        gen_inc   = 1'b1;
                        state_nxt = DRIVE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Settle wait counter, restarted on every DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (set_clr) begin
            settle_cnt <= '0;
        end else if (set_inc) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end
    end

    // busy tracks the sweep states of the upcoming cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt == DRIVE) || (state_nxt == SETTLE) || (state_nxt == SAMPLE);
        end
    end

    // Result capture: failure tally, first counterexample, done/pass flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            cex_valid  <= 1'b0;
            cex_x      <= '0;
            cex_y      <= '0;
        end else begin
            if (res_clr) begin
                done       <= 1'b0;
                pass       <= 1'b0;
                fail_count <= '0;
                cex_valid  <= 1'b0;
                cex_x      <= '0;
                cex_y      <= '0;
            end
            if (abort_en) begin
                done <= 1'b0;
                pass <= 1'b0;
            end
            if (sample_en) begin
                if (!bus.spec_ok) begin
                    fail_count <= CNT_W'(sat_inc(32'(fail_count), CNT_W));
                    if (!cex_valid) begin
                        cex_valid <= 1'b1;
                        cex_x     <= x_q;
                        cex_y     <= bus.y_in;
                    end
                end
                if (last_c) begin
                    done <= 1'b1;
                    pass <= bus.spec_ok && (fail_count == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// Bench for skolem_exhaustive_checker: three configurations driven by an xor-style netlist stub.
module tb_skolem_exhaustive_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, abort_a, start_b, abort_b, start_c, abort_c;

    logic       busy_a, done_a, pass_a, cv_a;
    logic [4:0] fc_a;
    logic [3:0] cx_a;
    logic [1:0] cy_a;
    logic       busy_b, done_b, pass_b, cv_b;
    logic [2:0] fc_b;
    logic [3:0] cx_b;
    logic [1:0] cy_b;
    logic       busy_c, done_c, pass_c, cv_c;
    logic [4:0] fc_c;
    logic [3:0] cx_c;
    logic [1:0] cy_c;

    logic [15:0] mask;
    logic [1:0]  corr [16];
    logic        force0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    skolem_exhaustive_checker_if #(.NUM_X(4), .NUM_Y(2)) ifa ();
    skolem_exhaustive_checker_if #(.NUM_X(4), .NUM_Y(2)) ifb ();
    skolem_exhaustive_checker_if #(.NUM_X(4), .NUM_Y(2)) ifc ();

    skolem_exhaustive_checker dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .bus(ifa),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
        .cex_valid(cv_a), .cex_x(cx_a), .cex_y(cy_a)
    );
    skolem_exhaustive_checker #(.CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .bus(ifb),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
        .cex_valid(cv_b), .cex_x(cx_b), .cex_y(cy_b)
    );
    skolem_exhaustive_checker #(.SETTLE_CYC(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .bus(ifc),
        .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c),
        .cex_valid(cv_c), .cex_x(cx_c), .cex_y(cy_c)
    );

    function automatic logic [1:0] good_y(input logic [3:0] x);
        return {x[3] ^ x[2], x[1] ^ x[0]};
    endfunction

    // Netlist stub: correct y unless the fault mask corrupts this x; evaluator compares to the true y.
    always_comb begin
        ifa.y_in    = good_y(ifa.x_out) ^ (mask[ifa.x_out] ? corr[ifa.x_out] : 2'b00);
        ifa.spec_ok = !force0 && (ifa.y_in == good_y(ifa.x_out));
        ifb.y_in    = good_y(ifb.x_out) ^ (mask[ifb.x_out] ? corr[ifb.x_out] : 2'b00);
        ifb.spec_ok = !force0 && (ifb.y_in == good_y(ifb.x_out));
        ifc.y_in    = good_y(ifc.x_out) ^ (mask[ifc.x_out] ? corr[ifc.x_out] : 2'b00);
        ifc.spec_ok = !force0 && (ifc.y_in == good_y(ifc.x_out));
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic get_st(input int w, output int b, output int d, output int p, output int fc,
                          output int cv, output int cx, output int cy, output int xo);
        case (w)
            0: begin b = busy_a; d = done_a; p = pass_a; fc = fc_a; cv = cv_a; cx = cx_a; cy = cy_a; xo = ifa.x_out; end
            1: begin b = busy_b; d = done_b; p = pass_b; fc = fc_b; cv = cv_b; cx = cx_b; cy = cy_b; xo = ifb.x_out; end
            default: begin b = busy_c; d = done_c; p = pass_c; fc = fc_c; cv = cv_c; cx = cx_c; cy = cy_c; xo = ifc.x_out; end
        endcase
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Pulse start, then count cycles with busy high (bounded).
    task automatic run_sweep(input int w, input int repulse, output int cycles);
        int b, d, p, fc, cv, cx, cy, xo;
        @(negedge clk); set_start(w, 1'b1);
        @(negedge clk); set_start(w, 1'b0);
        cycles = 0;
        get_st(w, b, d, p, fc, cv, cx, cy, xo);
        while (b == 1 && cycles < 500) begin
            cycles++;
            set_start(w, (cycles == repulse) ? 1'b1 : 1'b0);
            @(negedge clk);
            get_st(w, b, d, p, fc, cv, cx, cy, xo);
        end
        set_start(w, 1'b0);
    endtask

    task automatic check_result(input int w, input string tag, input int efc, input int ecv,
                                input int ecx, input int ecy, input int epass, input int ecyc,
                                input int cycles);
        int b, d, p, fc, cv, cx, cy, xo;
        get_st(w, b, d, p, fc, cv, cx, cy, xo);
        check({tag, ".cycles"}, cycles, ecyc);
        check({tag, ".busy"}, b, 0);
        check({tag, ".done"}, d, 1);
        check({tag, ".pass"}, p, epass);
        check({tag, ".fail_count"}, fc, efc);
        check({tag, ".cex_valid"}, cv, ecv);
        if (ecv != 0) begin
            check({tag, ".cex_x"}, cx, ecx);
            check({tag, ".cex_y"}, cy, ecy);
        end
    endtask

    // Reference: walk every x, count spec violations, remember the lowest failing x.
    task automatic model(input int cnt_max, output int efc, output int ecv, output int ecx,
                         output int ecy, output int epass);
        int fails;
        logic [1:0] y;
        logic [3:0] xv;
        fails = 0; ecv = 0; ecx = 0; ecy = 0;
        for (int x = 0; x < 16; x++) begin
            xv = 4'(x);
            y = good_y(xv) ^ (mask[x] ? corr[x] : 2'b00);
            if (force0 || y != good_y(xv)) begin
                fails++;
                if (ecv == 0) begin ecv = 1; ecx = x; ecy = y; end
            end
        end
        efc   = (fails > cnt_max) ? cnt_max : fails;
        epass = (fails == 0) ? 1 : 0;
    endtask

    typedef struct {
        logic [15:0] mask;
        int fails;
        int cv;
        int cx;
        int cy;
        int pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int cyc, b, d, p, fc, cv, cx, cy, xo;
        int efc, ecv, ecx, ecy, epass;

        // corr = 01 flips y0 of corrupted assignments
        tbl[0] = '{16'h0000, 0,  0, 0,  0, 1};
        tbl[1] = '{16'h0040, 1,  1, 6,  2, 0};
        tbl[2] = '{16'hFFFF, 16, 1, 0,  1, 0};
        tbl[3] = '{16'h8000, 1,  1, 15, 1, 0};
        tbl[4] = '{16'h0A00, 2,  1, 9,  2, 0};
        tbl[5] = '{16'h0003, 2,  1, 0,  1, 0};

        rst_n = 1'b0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; start_c = 0; abort_c = 0;
        force0 = 1'b0;
        mask = '0;
        for (int i = 0; i < 16; i++) corr[i] = 2'b01;

        #1;
        for (int w = 0; w < 3; w++) begin
            get_st(w, b, d, p, fc, cv, cx, cy, xo);
            check($sformatf("reset%0d.outputs", w), b + d + p + fc + cv + cx + cy + xo, 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors on the default configuration
        for (int i = 0; i < 6; i++) begin
            mask = tbl[i].mask;
            run_sweep(0, -1, cyc);
            check_result(0, $sformatf("tbl%0d", i), tbl[i].fails, tbl[i].cv, tbl[i].cx,
                         tbl[i].cy, tbl[i].pass, 48, cyc);
        end

        // spec_ok tied low: full count at default width, saturation at CNT_W=3
        mask = '0; force0 = 1'b1;
        run_sweep(0, -1, cyc);
        check_result(0, "tied0.a", 16, 1, 0, 0, 0, 48, cyc);
        run_sweep(1, -1, cyc);
        check_result(1, "tied0.b", 7, 1, 0, 0, 0, 48, cyc);
        force0 = 1'b0;

        // start re-pulsed mid-sweep is ignored
        run_sweep(0, 10, cyc);
        check_result(0, "repulse", 0, 0, 0, 0, 1, 48, cyc);

        // abort from DONE drops done and pass
        @(negedge clk); abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("abort_done.done", done_a, 0);
        check("abort_done.pass", pass_a, 0);

        // abort 20 cycles into a sweep where every x fails
        mask = 16'hFFFF;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (20) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("abort.busy", busy_a, 0);
        check("abort.done", done_a, 0);
        check("abort.fail_count", fc_a, 6);
        check("abort.cex_valid", cv_a, 1);
        check("abort.cex_x", cx_a, 0);
        check("abort.x_out", ifa.x_out, 6);
        repeat (4) @(negedge clk);
        check("abort_hold.fail_count", fc_a, 6);
        check("abort_hold.x_out", ifa.x_out, 6);

        // start and abort together from IDLE: abort wins
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
        check("start_abort.busy", busy_a, 0);
        repeat (3) @(negedge clk);
        check("start_abort.busy_later", busy_a, 0);
        check("start_abort.fail_count", fc_a, 6);

        // later start clears the partial result
        mask = '0;
        run_sweep(0, -1, cyc);
        check_result(0, "restart", 0, 0, 0, 0, 1, 48, cyc);

        // zero settle cycles
        mask = 16'h0040;
        run_sweep(2, -1, cyc);
        check_result(2, "settle0", 1, 1, 6, 2, 0, 32, cyc);

        // randomized fault patterns on all three configurations
        for (int it = 0; it < 6; it++) begin
            mask = (it % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            for (int i = 0; i < 16; i++) corr[i] = 2'($urandom_range(1, 3));
            model(31, efc, ecv, ecx, ecy, epass);
            run_sweep(0, -1, cyc);
            check_result(0, $sformatf("rnd%0d.a", it), efc, ecv, ecx, ecy, epass, 48, cyc);
            run_sweep(2, -1, cyc);
            check_result(2, $sformatf("rnd%0d.c", it), efc, ecv, ecx, ecy, epass, 32, cyc);
            model(7, efc, ecv, ecx, ecy, epass);
            run_sweep(1, -1, cyc);
            check_result(1, $sformatf("rnd%0d.b", it), efc, ecv, ecx, ecy, epass, 48, cyc);
        end

        // asynchronous reset in the middle of a sweep on the zero-settle instance
        mask = 16'hFFFF;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset.busy", busy_c, 1);
        #2 rst_n = 1'b0;
        #1;
        for (int w = 0; w < 3; w++) begin
            get_st(w, b, d, p, fc, cv, cx, cy, xo);
            check($sformatf("midreset%0d.outputs", w), b + d + p + fc + cv + cx + cy + xo, 0);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset.busy", busy_c, 0);
        check("post_reset.fail_count", fc_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
